// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates entries at dispatch, captures CDB/LSB results,
// serves operand lookups and commits one entry per cycle in program order.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             dispatch_rdy,
  input  logic [31:0]      up_inst,
  input  logic [31:0]      up_npc,
  input  logic [4:0]       up_rd,
  input  logic             rs_rdy,
  input  logic [TAG_W-1:0] rs_tag_bus,
  input  logic [31:0]      up_alu_output,
  input  logic [31:0]      alu_npc,
  input  logic             lsb_rdy,
  input  logic [TAG_W-1:0] lsb_tag_bus,
  input  logic [31:0]      up_lmd_output,
  input  logic [TAG_W-1:0] rs1_rely,
  input  logic [TAG_W-1:0] rs2_rely,
  output logic             ROB_rs1_valid,
  output logic             ROB_rs1_mem_in_need,
  output logic [31:0]      ROB_rs1_alu_output,
  output logic [31:0]      ROB_rs1_lmd_output,
  output logic             ROB_rs2_valid,
  output logic             ROB_rs2_mem_in_need,
  output logic [31:0]      ROB_rs2_alu_output,
  output logic [31:0]      ROB_rs2_lmd_output,
  output logic [TAG_W-1:0] ROB_next_tag,
  output logic [TAG_W-1:0] head_tag,
  output logic             ROB_FULL,
  output logic             enable_write,
  output logic             write_rdy,
  output logic [4:0]       to_rd,
  output logic [31:0]      write_val,
  output logic             commit_pulse,
  output logic [31:0]      to_pc,
  output logic             clear
);

  typedef enum logic [2:0] {
    K_ALU    = 3'd0,
    K_LOAD   = 3'd1,
    K_STORE  = 3'd2,
    K_BRANCH = 3'd3,
    K_JUMP   = 3'd4
  } kind_t;

  logic        r_busy     [DEPTH];
  logic        r_ready    [DEPTH];
  kind_t       r_kind     [DEPTH];
  logic [4:0]  r_rd       [DEPTH];
  logic [31:0] r_pred_npc [DEPTH];
  logic [31:0] r_alu_val  [DEPTH];
  logic [31:0] r_lmd_val  [DEPTH];
  logic [31:0] r_real_npc [DEPTH];

  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  logic        r_write_rdy;
  logic [4:0]  r_to_rd;
  logic [31:0] r_write_val;
  logic        r_commit_pulse;
  logic [31:0] r_to_pc;
  logic        r_clear;

  kind_t w_up_kind;
  kind_t w_head_kind;
  logic  w_commit;
  logic  w_mispredict;
  logic  w_writes_rd;
  logic  w_alloc;

  always_comb begin
    w_up_kind = K_ALU;
    case (up_inst[6:0])
      7'b0000011:             w_up_kind = K_LOAD;
      7'b0100011:             w_up_kind = K_STORE;
      7'b1100011:             w_up_kind = K_BRANCH;
      7'b1101111, 7'b1100111: w_up_kind = K_JUMP;
      default:                w_up_kind = K_ALU;
    endcase
  end

  assign w_head_kind  = r_kind[r_head];
  assign w_commit     = r_busy[r_head] & r_ready[r_head];
  assign w_mispredict = w_commit & ((w_head_kind == K_BRANCH) | (w_head_kind == K_JUMP))
                      & (r_real_npc[r_head] != r_pred_npc[r_head]);
  assign w_writes_rd  = w_commit & (r_rd[r_head] != 5'd0)
                      & ((w_head_kind == K_ALU) | (w_head_kind == K_LOAD) | (w_head_kind == K_JUMP));
  // Dispatch is also dropped during the clear pulse while fetch is being redirected.
  assign w_alloc      = dispatch_rdy & ~r_clear & ~w_mispredict & (r_count < (TAG_W+1)'(DEPTH));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_busy[i]     <= 1'b0;
        r_ready[i]    <= 1'b0;
        r_kind[i]     <= K_ALU;
        r_rd[i]       <= 5'd0;
        r_pred_npc[i] <= 32'd0;
        r_alu_val[i]  <= 32'd0;
        r_lmd_val[i]  <= 32'd0;
        r_real_npc[i] <= 32'd0;
      end
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_write_rdy    <= 1'b0;
      r_to_rd        <= 5'd0;
      r_write_val    <= 32'd0;
      r_commit_pulse <= 1'b0;
      r_to_pc        <= 32'd0;
      r_clear        <= 1'b0;
    end else if (rdy_in) begin
      r_write_rdy    <= w_writes_rd;
      r_commit_pulse <= w_commit;
      r_clear        <= w_mispredict;
      if (w_writes_rd) begin
        r_to_rd     <= r_rd[r_head];
        r_write_val <= (w_head_kind == K_LOAD) ? r_lmd_val[r_head] : r_alu_val[r_head];
      end
      if (w_mispredict) begin
        r_to_pc <= r_real_npc[r_head];
        for (int i = 0; i < DEPTH; i++) begin
          r_busy[i]  <= 1'b0;
          r_ready[i] <= 1'b0;
        end
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (rs_rdy && r_busy[rs_tag_bus]) begin
          r_alu_val[rs_tag_bus]  <= up_alu_output;
          r_real_npc[rs_tag_bus] <= alu_npc;
          r_ready[rs_tag_bus]    <= 1'b1;
        end
        if (lsb_rdy && r_busy[lsb_tag_bus]) begin
          r_lmd_val[lsb_tag_bus] <= up_lmd_output;
          r_ready[lsb_tag_bus]   <= 1'b1;
        end
        // Head and tail cannot alias while both fire: commit needs count>0, alloc needs count<DEPTH.
        if (w_commit) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + TAG_W'(1);
        end
        if (w_alloc) begin
          r_busy[r_tail]     <= 1'b1;
          r_ready[r_tail]    <= 1'b0;
          r_kind[r_tail]     <= w_up_kind;
          r_rd[r_tail]       <= up_rd;
          r_pred_npc[r_tail] <= up_npc;
          r_tail             <= r_tail + TAG_W'(1);
        end
        case ({w_alloc, w_commit})
          2'b10:   r_count <= r_count + (TAG_W+1)'(1);
          2'b01:   r_count <= r_count - (TAG_W+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign ROB_rs1_valid       = r_busy[rs1_rely] & r_ready[rs1_rely];
  assign ROB_rs1_mem_in_need = (r_kind[rs1_rely] == K_LOAD);
  assign ROB_rs1_alu_output  = r_alu_val[rs1_rely];
  assign ROB_rs1_lmd_output  = r_lmd_val[rs1_rely];
  assign ROB_rs2_valid       = r_busy[rs2_rely] & r_ready[rs2_rely];
  assign ROB_rs2_mem_in_need = (r_kind[rs2_rely] == K_LOAD);
  assign ROB_rs2_alu_output  = r_alu_val[rs2_rely];
  assign ROB_rs2_lmd_output  = r_lmd_val[rs2_rely];

  assign ROB_next_tag = r_tail;
  assign head_tag     = r_head;
  assign ROB_FULL     = (r_count >= (TAG_W+1)'(DEPTH - 2));
  assign enable_write = r_busy[r_head] & (r_kind[r_head] == K_STORE) & ~r_ready[r_head];

  assign write_rdy    = r_write_rdy;
  assign to_rd        = r_to_rd;
  assign write_val    = r_write_val;
  assign commit_pulse = r_commit_pulse;
  assign to_pc        = r_to_pc;
  assign clear        = r_clear;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed stimulus, commit scoreboard with a monitor process.
module tb_reorder_buffer;

  localparam logic [31:0] ADDI   = 32'h0000_0013;
  localparam logic [31:0] LOAD   = 32'h0000_0003;
  localparam logic [31:0] STORE  = 32'h0000_0023;
  localparam logic [31:0] BRANCH = 32'h0000_0063;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        dispatch_rdy = 1'b0;
  logic [31:0] up_inst = 32'd0;
  logic [31:0] up_npc = 32'd0;
  logic [4:0]  up_rd = 5'd0;
  logic        rs_rdy = 1'b0;
  logic [3:0]  rs_tag_bus = 4'd0;
  logic [31:0] up_alu_output = 32'd0;
  logic [31:0] alu_npc = 32'd0;
  logic        lsb_rdy = 1'b0;
  logic [3:0]  lsb_tag_bus = 4'd0;
  logic [31:0] up_lmd_output = 32'd0;
  logic [3:0]  rs1_rely = 4'd0;
  logic [3:0]  rs2_rely = 4'd0;
  logic        ROB_rs1_valid, ROB_rs1_mem_in_need, ROB_rs2_valid, ROB_rs2_mem_in_need;
  logic [31:0] ROB_rs1_alu_output, ROB_rs1_lmd_output, ROB_rs2_alu_output, ROB_rs2_lmd_output;
  logic [3:0]  ROB_next_tag, head_tag;
  logic        ROB_FULL, enable_write, write_rdy, commit_pulse, clear;
  logic [4:0]  to_rd;
  logic [31:0] write_val, to_pc;

  reorder_buffer #(.DEPTH(16), .TAG_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dispatch_rdy(dispatch_rdy), .up_inst(up_inst), .up_npc(up_npc), .up_rd(up_rd),
    .rs_rdy(rs_rdy), .rs_tag_bus(rs_tag_bus), .up_alu_output(up_alu_output), .alu_npc(alu_npc),
    .lsb_rdy(lsb_rdy), .lsb_tag_bus(lsb_tag_bus), .up_lmd_output(up_lmd_output),
    .rs1_rely(rs1_rely), .rs2_rely(rs2_rely),
    .ROB_rs1_valid(ROB_rs1_valid), .ROB_rs1_mem_in_need(ROB_rs1_mem_in_need),
    .ROB_rs1_alu_output(ROB_rs1_alu_output), .ROB_rs1_lmd_output(ROB_rs1_lmd_output),
    .ROB_rs2_valid(ROB_rs2_valid), .ROB_rs2_mem_in_need(ROB_rs2_mem_in_need),
    .ROB_rs2_alu_output(ROB_rs2_alu_output), .ROB_rs2_lmd_output(ROB_rs2_lmd_output),
    .ROB_next_tag(ROB_next_tag), .head_tag(head_tag), .ROB_FULL(ROB_FULL),
    .enable_write(enable_write), .write_rdy(write_rdy), .to_rd(to_rd), .write_val(write_val),
    .commit_pulse(commit_pulse), .to_pc(to_pc), .clear(clear)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        clr;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic wr, input logic [4:0] rd, input logic [31:0] val,
                          input logic clr, input logic [31:0] pc);
    exp_t e;
    e.wr = wr; e.rd = rd; e.val = val; e.clr = clr; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // scoreboard monitor: one expected entry per commit pulse
  always @(negedge clk_in) begin
    if (rst_in && commit_pulse) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_commit: got commit_pulse=1 expected none at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("commit_write_rdy", 32'(write_rdy), 32'(e.wr));
        if (e.wr) begin
          check("commit_to_rd", 32'(to_rd), 32'(e.rd));
          check("commit_write_val", write_val, e.val);
        end
        check("commit_clear", 32'(clear), 32'(e.clr));
        if (e.clr) check("commit_to_pc", to_pc, e.pc);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic dispatch(input logic [31:0] inst, input logic [31:0] npc, input logic [4:0] rd);
    dispatch_rdy = 1'b1; up_inst = inst; up_npc = npc; up_rd = rd;
    tick();
    dispatch_rdy = 1'b0;
  endtask

  task automatic alu_done(input logic [3:0] tag, input logic [31:0] val, input logic [31:0] npc);
    rs_rdy = 1'b1; rs_tag_bus = tag; up_alu_output = val; alu_npc = npc;
    tick();
    rs_rdy = 1'b0;
  endtask

  task automatic lsb_done(input logic [3:0] tag, input logic [31:0] data);
    lsb_rdy = 1'b1; lsb_tag_bus = tag; up_lmd_output = data;
    tick();
    lsb_rdy = 1'b0;
  endtask

  initial begin
    #2;
    check("reset_next_tag", 32'(ROB_next_tag), 32'd0);
    check("reset_head_tag", 32'(head_tag), 32'd0);
    check("reset_full", 32'(ROB_FULL), 32'd0);
    check("reset_write_rdy", 32'(write_rdy), 32'd0);
    check("reset_commit_pulse", 32'(commit_pulse), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();

    // ALU commit at tag 0
    dispatch(ADDI, 32'h4, 5'd5);
    check("alu_next_tag", 32'(ROB_next_tag), 32'd1);
    rs1_rely = 4'd0;
    #1 check("alu_not_ready", 32'(ROB_rs1_valid), 32'd0);
    alu_done(4'd0, 32'h2A, 32'h4);
    check("alu_lookup_valid", 32'(ROB_rs1_valid), 32'd1);
    check("alu_lookup_val", ROB_rs1_alu_output, 32'h2A);
    push_exp(1'b1, 5'd5, 32'h2A, 1'b0, 32'd0);
    tick(); tick();

    // load forwarding at tag 1
    dispatch(LOAD, 32'h8, 5'd3);
    lsb_done(4'd1, 32'hDEADBEEF);
    rs1_rely = 4'd1;
    #1;
    check("load_lookup_valid", 32'(ROB_rs1_valid), 32'd1);
    check("load_mem_in_need", 32'(ROB_rs1_mem_in_need), 32'd1);
    check("load_lookup_lmd", ROB_rs1_lmd_output, 32'hDEADBEEF);
    push_exp(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 32'd0);
    tick(); tick();

    // store at head, tag 2
    dispatch(STORE, 32'hC, 5'd0);
    check("store_enable_write", 32'(enable_write), 32'd1);
    rs2_rely = 4'd2;
    #1 check("store_not_load", 32'(ROB_rs2_mem_in_need), 32'd0);
    lsb_done(4'd2, 32'd0);
    check("store_enable_write_off", 32'(enable_write), 32'd0);
    push_exp(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    tick(); tick();
    check("store_head_tag", 32'(head_tag), 32'd3);

    // out-of-order completion: tags 3,4
    dispatch(ADDI, 32'h10, 5'd7);
    dispatch(ADDI, 32'h14, 5'd8);
    alu_done(4'd4, 32'h44, 32'h18);
    tick(); tick();
    check("ooo_head_blocked", 32'(head_tag), 32'd3);
    alu_done(4'd3, 32'h33, 32'h14);
    push_exp(1'b1, 5'd7, 32'h33, 1'b0, 32'd0);
    push_exp(1'b1, 5'd8, 32'h44, 1'b0, 32'd0);
    tick();
    check("ooo_head_after_first", 32'(head_tag), 32'd4);
    tick();
    check("ooo_head_after_second", 32'(head_tag), 32'd5);

    // mispredicted branch at tag 5 with younger entries 6,7
    dispatch(BRANCH, 32'h104, 5'd0);
    dispatch(ADDI, 32'h108, 5'd9);
    dispatch(ADDI, 32'h10C, 5'd10);
    alu_done(4'd5, 32'd0, 32'h200);
    push_exp(1'b0, 5'd0, 32'd0, 1'b1, 32'h200);
    tick();
    check("flush_next_tag", 32'(ROB_next_tag), 32'd0);
    check("flush_head_tag", 32'(head_tag), 32'd0);
    alu_done(4'd6, 32'h66, 32'h10C);
    rs1_rely = 4'd6;
    #1 check("flush_dropped_entry", 32'(ROB_rs1_valid), 32'd0);
    tick(); tick();

    // fill to the full threshold, then drain and wrap
    for (int i = 0; i < 14; i++) begin
      dispatch(ADDI, 32'h400 + 32'(i * 4), 5'(i + 1));
      if (i == 12) check("full_at_13", 32'(ROB_FULL), 32'd0);
      if (i == 13) check("full_at_14", 32'(ROB_FULL), 32'd1);
    end
    check("full_next_tag", 32'(ROB_next_tag), 32'd14);
    for (int i = 0; i < 14; i++) begin
      alu_done(4'(i), 32'h100 + 32'(i), 32'd0);
      push_exp(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b0, 32'd0);
    end
    tick(); tick(); tick();
    check("drain_head_tag", 32'(head_tag), 32'd14);
    check("drain_not_full", 32'(ROB_FULL), 32'd0);
    for (int i = 0; i < 4; i++) dispatch(ADDI, 32'h800, 5'(20 + i));
    check("wrap_next_tag", 32'(ROB_next_tag), 32'd2);
    for (int i = 0; i < 4; i++) begin
      alu_done(4'(14 + i), 32'hA00 + 32'(i), 32'd0);
      push_exp(1'b1, 5'(20 + i), 32'hA00 + 32'(i), 1'b0, 32'd0);
    end
    tick(); tick(); tick();
    check("wrap_head_tag", 32'(head_tag), 32'd2);

    // rdy_in low freezes allocation
    rdy_in = 1'b0;
    dispatch(ADDI, 32'h900, 5'd1);
    check("freeze_next_tag", 32'(ROB_next_tag), 32'd2);
    rdy_in = 1'b1;

    // reset mid-run while write_rdy is high
    dispatch(ADDI, 32'h904, 5'd4);
    alu_done(4'd2, 32'h77, 32'd0);
    push_exp(1'b1, 5'd4, 32'h77, 1'b0, 32'd0);
    dispatch(ADDI, 32'h908, 5'd6);
    #6;
    rst_in = 1'b0;
    #1;
    check("midreset_next_tag", 32'(ROB_next_tag), 32'd0);
    check("midreset_head_tag", 32'(head_tag), 32'd0);
    check("midreset_full", 32'(ROB_FULL), 32'd0);
    check("midreset_clear", 32'(clear), 32'd0);
    check("midreset_write_rdy", 32'(write_rdy), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    tick(); tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
